// File: rtl/vend_sequencer.sv
// vend_sequencer: vending machine transaction controller.
// Owns the credit register and steps each purchase through coin entry,
// keypad selection, price/stock check, dispense and change handshakes.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   coin_valid, coin_code[4:0]   one-hot coin pulse (5/10/20/50/100)
//   key_valid, key_code[3:0]     keypad pulse (0-9 digit, 10 cancel, 11 enter)
//   price_of_all[79:0]           byte k-1 = price of product k (0 = unconfigured)
//   stock_empty[9:0]             bit k-1 = product k out of stock
//   dispense_req/id, dispense_ack   dispense handshake
//   change_req/amount, change_ack   change payout handshake
//   credit[7:0], busy            current balance, busy in CHECK/DISPENSE/CHANGE
//   err_*                        single-cycle error pulses
module vend_sequencer #(
    parameter int unsigned NUM_PRODUCTS = 10,  // at most 10
    parameter int unsigned SEL_TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        coin_valid,
    input  logic [4:0]  coin_code,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic [79:0] price_of_all,
    input  logic [9:0]  stock_empty,
    output logic        dispense_req,
    output logic [3:0]  dispense_id,
    input  logic        dispense_ack,
    output logic        change_req,
    output logic [7:0]  change_amount,
    input  logic        change_ack,
    output logic [7:0]  credit,
    output logic        busy,
    output logic        err_invalid_coin,
    output logic        err_coin_reject,
    output logic        err_bad_select,
    output logic        err_out_of_stock,
    output logic        err_insufficient
);

    localparam int unsigned TW = (SEL_TIMEOUT > 1) ? $clog2(SEL_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(SEL_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SELECT, CHECK, DISPENSE, CHANGE} state_t;

    state_t        state, state_nx;
    logic [7:0]    sel, sel_nx;
    logic          two_digits, two_digits_nx;
    logic          ovf, ovf_nx;
    logic [TW-1:0] tmo, tmo_nx;

    logic       dispense_req_nx, change_req_nx, busy_nx;
    logic [3:0] dispense_id_nx;
    logic [7:0] change_amount_nx, credit_nx;
    logic       err_invalid_coin_nx, err_coin_reject_nx, err_bad_select_nx;
    logic       err_out_of_stock_nx, err_insufficient_nx;

    logic [7:0] coin_val;
    logic       coin_ok;
    logic [8:0] coin_sum;
    logic [7:0] sel_price;
    logic       sel_stock_empty;
    logic       key_digit, key_cancel, key_enter;

    always_comb begin
        coin_ok  = 1'b1;
        coin_val = '0;
        case (coin_code)
            5'b00001: coin_val = 8'd5;
            5'b00010: coin_val = 8'd10;
            5'b00100: coin_val = 8'd20;
            5'b01000: coin_val = 8'd50;
            5'b10000: coin_val = 8'd100;
            default:  coin_ok  = 1'b0;
        endcase
        coin_sum = {1'b0, credit} + {1'b0, coin_val};
    end

    // Out-of-range selections read as price 0, so they fail the price test too.
    always_comb begin
        sel_price       = '0;
        sel_stock_empty = 1'b0;
        for (int unsigned k = 1; k <= NUM_PRODUCTS; k++) begin
            if (sel == 8'(k)) begin
                sel_price       = price_of_all[8*(k-1) +: 8];
                sel_stock_empty = stock_empty[k-1];
            end
        end
    end

    assign key_digit  = key_valid && (key_code <= 4'd9);
    assign key_cancel = key_valid && (key_code == 4'd10);
    assign key_enter  = key_valid && (key_code == 4'd11);

    always_comb begin
        state_nx            = state;
        sel_nx              = sel;
        two_digits_nx       = two_digits;
        ovf_nx              = ovf;
        tmo_nx              = tmo;
        credit_nx           = credit;
        dispense_id_nx      = dispense_id;
        change_amount_nx    = change_amount;
        err_invalid_coin_nx = 1'b0;
        err_coin_reject_nx  = 1'b0;
        err_bad_select_nx   = 1'b0;
        err_out_of_stock_nx = 1'b0;
        err_insufficient_nx = 1'b0;

        if (coin_valid) begin
            if (state == IDLE || state == SELECT) begin
                if (!coin_ok)
                    err_invalid_coin_nx = 1'b1;
                else if (coin_sum[8])
                    err_coin_reject_nx = 1'b1;
                else
                    credit_nx = coin_sum[7:0];
            end else begin
                err_coin_reject_nx = 1'b1;
            end
        end

        // Cancel decisions use the post-coin credit so a same-cycle coin is refunded.
        case (state)
            IDLE: begin
                if (key_digit) begin
                    sel_nx        = {4'b0, key_code};
                    two_digits_nx = 1'b0;
                    ovf_nx        = 1'b0;
                    tmo_nx        = TMO_LOAD;
                    state_nx      = SELECT;
                end else if (key_enter) begin
                    err_bad_select_nx = 1'b1;
                end else if (key_cancel && credit_nx != 8'd0) begin
                    state_nx = CHANGE;
                end
            end
            SELECT: begin
                if (key_digit) begin
                    tmo_nx = TMO_LOAD;
                    if (!two_digits) begin
                        sel_nx        = sel * 8'd10 + {4'b0, key_code};
                        two_digits_nx = 1'b1;
                    end else begin
                        ovf_nx = 1'b1;
                    end
                end else if (key_cancel) begin
                    state_nx = (credit_nx != 8'd0) ? CHANGE : IDLE;
                end else if (key_enter) begin
                    if (ovf || sel == 8'd0 || sel > 8'(NUM_PRODUCTS) || sel_price == 8'd0) begin
                        err_bad_select_nx = 1'b1;
                        state_nx          = IDLE;
                    end else begin
                        state_nx = CHECK;
                    end
                end else if (tmo == '0) begin
                    state_nx = IDLE;
                end else begin
                    tmo_nx = tmo - TW'(1);
                end
            end
            CHECK: begin
                if (sel_stock_empty) begin
                    err_out_of_stock_nx = 1'b1;
                    state_nx            = IDLE;
                end else if (credit < sel_price) begin
                    err_insufficient_nx = 1'b1;
                    state_nx            = IDLE;
                end else begin
                    credit_nx      = credit - sel_price;
                    dispense_id_nx = sel[3:0];
                    state_nx       = DISPENSE;
                end
            end
            DISPENSE: begin
                if (dispense_ack)
                    state_nx = (credit != 8'd0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (change_ack) begin
                    credit_nx = '0;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Level outputs are registered from the next state.
        dispense_req_nx = (state_nx == DISPENSE);
        change_req_nx   = (state_nx == CHANGE);
        busy_nx         = (state_nx == CHECK) || (state_nx == DISPENSE) || (state_nx == CHANGE);
        if (state_nx == CHANGE)
            change_amount_nx = credit_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            sel              <= '0;
            two_digits       <= 1'b0;
            ovf              <= 1'b0;
            tmo              <= '0;
            credit           <= '0;
            dispense_req     <= 1'b0;
            dispense_id      <= '0;
            change_req       <= 1'b0;
            change_amount    <= '0;
            busy             <= 1'b0;
            err_invalid_coin <= 1'b0;
            err_coin_reject  <= 1'b0;
            err_bad_select   <= 1'b0;
            err_out_of_stock <= 1'b0;
            err_insufficient <= 1'b0;
        end else begin
            state            <= state_nx;
            sel              <= sel_nx;
            two_digits       <= two_digits_nx;
            ovf              <= ovf_nx;
            tmo              <= tmo_nx;
            credit           <= credit_nx;
            dispense_req     <= dispense_req_nx;
            dispense_id      <= dispense_id_nx;
            change_req       <= change_req_nx;
            change_amount    <= change_amount_nx;
            busy             <= busy_nx;
            err_invalid_coin <= err_invalid_coin_nx;
            err_coin_reject  <= err_coin_reject_nx;
            err_bad_select   <= err_bad_select_nx;
            err_out_of_stock <= err_out_of_stock_nx;
            err_insufficient <= err_insufficient_nx;
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed self-checking bench for vend_sequencer.
// Expected values are queued as stimulus is driven and popped when the
// corresponding DUT output is sampled (1 time unit after the active edge).
module tb_vend_sequencer;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        coin_valid;
    logic [4:0]  coin_code;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [79:0] price_of_all;
    logic [9:0]  stock_empty;
    logic        dispense_req;
    logic [3:0]  dispense_id;
    logic        dispense_ack;
    logic        change_req;
    logic [7:0]  change_amount;
    logic        change_ack;
    logic [7:0]  credit;
    logic        busy;
    logic        err_invalid_coin, err_coin_reject, err_bad_select;
    logic        err_out_of_stock, err_insufficient;

    vend_sequencer #(.NUM_PRODUCTS(10), .SEL_TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .coin_valid(coin_valid), .coin_code(coin_code),
        .key_valid(key_valid), .key_code(key_code),
        .price_of_all(price_of_all), .stock_empty(stock_empty),
        .dispense_req(dispense_req), .dispense_id(dispense_id), .dispense_ack(dispense_ack),
        .change_req(change_req), .change_amount(change_amount), .change_ack(change_ack),
        .credit(credit), .busy(busy),
        .err_invalid_coin(err_invalid_coin), .err_coin_reject(err_coin_reject),
        .err_bad_select(err_bad_select), .err_out_of_stock(err_out_of_stock),
        .err_insufficient(err_insufficient)
    );

    always #5 clk = ~clk;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_empty: observed %0d, no expected value queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            n_assert++;
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", t, obs, e);
            end
        end
    endtask

    task automatic coin(input logic [4:0] c);
        coin_valid = 1'b1;
        coin_code  = c;
        tick();
        coin_valid = 1'b0;
        coin_code  = '0;
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = '0;
    endtask

    task automatic ack_dispense();
        dispense_ack = 1'b1;
        tick();
        dispense_ack = 1'b0;
    endtask

    task automatic ack_change();
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        coin_valid = 1'b0; coin_code = '0;
        key_valid = 1'b0;  key_code = '0;
        dispense_ack = 1'b0; change_ack = 1'b0;
        stock_empty = '0;
        price_of_all = '0;
        price_of_all[8*0 +: 8] = 8'd10;   // product 1
        price_of_all[8*1 +: 8] = 8'd60;   // product 2
        price_of_all[8*2 +: 8] = 8'd45;   // product 3
        price_of_all[8*4 +: 8] = 8'd15;   // product 5
        price_of_all[8*9 +: 8] = 8'd30;   // product 10

        // Reset state
        expect_val("rst_credit", 0);
        expect_val("rst_dreq", 0);
        expect_val("rst_creq", 0);
        expect_val("rst_busy", 0);
        expect_val("rst_did", 0);
        expect_val("rst_camt", 0);
        tick(); tick();
        observe(32'(credit)); observe(32'(dispense_req)); observe(32'(change_req));
        observe(32'(busy)); observe(32'(dispense_id)); observe(32'(change_amount));
        reset_n = 1'b1;
        tick();

        // Purchase: 50+20, product 3 @45
        expect_val("coin50_credit", 50);
        coin(5'b01000); observe(32'(credit));
        expect_val("coin20_credit", 70);
        coin(5'b00100); observe(32'(credit));
        key(4'd3);
        expect_val("check_busy", 1);
        expect_val("check_dreq", 0);
        key(4'd11); observe(32'(busy)); observe(32'(dispense_req));
        expect_val("disp_req", 1);
        expect_val("disp_id", 3);
        expect_val("disp_credit", 25);
        tick(); observe(32'(dispense_req)); observe(32'(dispense_id)); observe(32'(credit));
        expect_val("disp_coin_reject", 1);
        expect_val("disp_coin_credit", 25);
        coin(5'b00010); observe(32'(err_coin_reject)); observe(32'(credit));
        expect_val("reject_pulse_end", 0);
        expect_val("disp_req_held", 1);
        tick(); observe(32'(err_coin_reject)); observe(32'(dispense_req));
        expect_val("dack_dreq", 0);
        expect_val("dack_creq", 1);
        expect_val("dack_camt", 25);
        ack_dispense(); observe(32'(dispense_req)); observe(32'(change_req)); observe(32'(change_amount));
        expect_val("cack_creq", 0);
        expect_val("cack_credit", 0);
        expect_val("cack_busy", 0);
        ack_change(); observe(32'(change_req)); observe(32'(credit)); observe(32'(busy));

        // Insufficient: credit 20, product 10 @30
        coin(5'b00100);
        key(4'd1); key(4'd0); key(4'd11);
        expect_val("insuf_err", 1);
        expect_val("insuf_credit", 20);
        expect_val("insuf_dreq", 0);
        tick(); observe(32'(err_insufficient)); observe(32'(credit)); observe(32'(dispense_req));
        expect_val("insuf_pulse_end", 0);
        expect_val("insuf_busy", 0);
        tick(); observe(32'(err_insufficient)); observe(32'(busy));

        // Bad selections
        key(4'd1); key(4'd1);
        expect_val("sel11_bad", 1);
        expect_val("sel11_busy", 0);
        key(4'd11); observe(32'(err_bad_select)); observe(32'(busy));
        expect_val("idle_enter_pulse_end", 0);
        tick(); observe(32'(err_bad_select));
        expect_val("idle_enter_bad", 1);
        key(4'd11); observe(32'(err_bad_select));

        // Out of stock: product 5 @15, credit 20 suffices
        stock_empty = 10'b00000_10000;
        key(4'd5); key(4'd11);
        expect_val("oos_err", 1);
        expect_val("oos_insuf", 0);
        expect_val("oos_dreq", 0);
        tick(); observe(32'(err_out_of_stock)); observe(32'(err_insufficient)); observe(32'(dispense_req));
        stock_empty = '0;

        // Cancel from IDLE refunds 20
        expect_val("cancel_creq", 1);
        expect_val("cancel_camt", 20);
        key(4'd10); observe(32'(change_req)); observe(32'(change_amount));
        expect_val("cancel_credit0", 0);
        ack_change(); observe(32'(credit));

        // Coin overflow and invalid code
        coin(5'b10000); coin(5'b10000);
        expect_val("ovf_reject", 1);
        expect_val("ovf_credit", 200);
        coin(5'b10000); observe(32'(err_coin_reject)); observe(32'(credit));
        expect_val("invalid_err", 1);
        expect_val("invalid_reject", 0);
        expect_val("invalid_credit", 200);
        coin(5'b00011); observe(32'(err_invalid_coin)); observe(32'(err_coin_reject)); observe(32'(credit));
        key(4'd10);
        expect_val("refund200", 0);
        ack_change(); observe(32'(credit));

        // Selection timeout: not yet expired one cycle early
        coin(5'b00100); coin(5'b00100);
        key(4'd2);
        for (int i = 0; i < int'(TMO) - 2; i++) tick();
        expect_val("tmo_early_busy", 1);
        key(4'd11); observe(32'(busy));
        expect_val("tmo_early_insuf", 1);
        tick(); observe(32'(err_insufficient));
        // Full timeout returns to IDLE with credit kept
        key(4'd2);
        for (int i = 0; i < int'(TMO); i++) tick();
        expect_val("tmo_credit", 40);
        observe(32'(credit));
        expect_val("tmo_enter_bad", 1);
        expect_val("tmo_enter_busy", 0);
        key(4'd11); observe(32'(err_bad_select)); observe(32'(busy));
        expect_val("tmo_cancel_creq", 1);
        expect_val("tmo_cancel_camt", 40);
        key(4'd10); observe(32'(change_req)); observe(32'(change_amount));
        ack_change();

        // Reset mid-dispense
        coin(5'b01000);
        key(4'd1); key(4'd11);
        expect_val("pre_rst_dreq", 1);
        expect_val("pre_rst_credit", 40);
        tick(); observe(32'(dispense_req)); observe(32'(credit));
        reset_n = 1'b0;
        #2;
        expect_val("async_rst_dreq", 0);
        expect_val("async_rst_credit", 0);
        expect_val("async_rst_busy", 0);
        observe(32'(dispense_req)); observe(32'(credit)); observe(32'(busy));
        tick();
        reset_n = 1'b1;
        tick();

        // Fresh purchase after reset, with change
        expect_val("post_rst_coin", 20);
        coin(5'b00100); observe(32'(credit));
        key(4'd1); key(4'd11);
        expect_val("post_rst_dreq", 1);
        expect_val("post_rst_did", 1);
        expect_val("post_rst_credit", 10);
        tick(); observe(32'(dispense_req)); observe(32'(dispense_id)); observe(32'(credit));
        expect_val("post_rst_creq", 1);
        expect_val("post_rst_camt", 10);
        ack_dispense(); observe(32'(change_req)); observe(32'(change_amount));
        expect_val("post_rst_done", 0);
        ack_change(); observe(32'(credit));

        // Exact credit: no change phase, stray ack ignored
        coin(5'b00010);
        key(4'd1); key(4'd11);
        expect_val("exact_credit", 0);
        tick(); observe(32'(credit));
        expect_val("exact_no_creq", 0);
        expect_val("exact_busy", 0);
        ack_dispense(); observe(32'(change_req)); observe(32'(busy));
        expect_val("stray_ack_creq", 0);
        ack_change(); observe(32'(change_req));

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
